// File: rtl/vga_sync_ctrl_if.sv
// VGA timing bundle: sync, blanking, tick and pixel coordinates
// produced by the timing controller for the text and RGB stages.
interface vga_sync_ctrl_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       p_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       frame_start;

  modport master (
    output hsync, vsync, video_on, p_tick, pixel_x, pixel_y, frame_start
  );

  modport slave (
    input hsync, vsync, video_on, p_tick, pixel_x, pixel_y, frame_start
  );
endinterface

// File: rtl/vga_sync_ctrl.sv
// VGA timing controller: pixel-tick divider, horizontal/vertical
// counters, registered sync/blank decode and a frame-start strobe.
module vga_sync_ctrl #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int TICK_DIV  = 4
) (
  input  logic            clk,
  input  logic            rst,
  vga_sync_ctrl_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0]       V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0]       HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]       HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0]       VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]       VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_nxt;
  logic [9:0]       x_q, x_nxt;
  logic [9:0]       y_q, y_nxt;
  logic             tick_q, hsync_q, vsync_q, video_q, frame_q;
  logic             frame_wrap;

  // Next-state divider and counters; counters only move at the edge
  // that closes a p_tick cycle.
  always_comb begin
    div_nxt    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    x_nxt      = x_q;
    y_nxt      = y_q;
    frame_wrap = 1'b0;
    if (tick_q) begin
      if (x_q == H_LAST) begin
        x_nxt = '0;
        if (y_q == V_LAST) begin
          y_nxt      = '0;
          frame_wrap = 1'b1;
        end else begin
          y_nxt = y_q + 1'b1;
        end
      end else begin
        x_nxt = x_q + 1'b1;
      end
    end
  end

  // Registered state; decoded outputs use next-state counters so they
  // change on the same edge as pixel_x/pixel_y.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      tick_q  <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      video_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_nxt;
      x_q     <= x_nxt;
      y_q     <= y_nxt;
      tick_q  <= (div_nxt == DIV_LAST);
      hsync_q <= !((x_nxt >= HS_START) && (x_nxt < HS_END));
      vsync_q <= !((y_nxt >= VS_START) && (y_nxt < VS_END));
      video_q <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
      frame_q <= frame_wrap;
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_q;
  assign vga.p_tick      = tick_q;
  assign vga.pixel_x     = x_q;
  assign vga.pixel_y     = y_q;
  assign vga.frame_start = frame_q;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Bench for vga_sync_ctrl: default timing instance plus a tiny-frame
// instance, checked against closed-form timing expectations.
module tb_vga_sync_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  vga_sync_ctrl_if bus_def ();
  vga_sync_ctrl_if bus_sm ();

  vga_sync_ctrl u_def (
    .clk (clk),
    .rst (rst),
    .vga (bus_def)
  );

  vga_sync_ctrl #(
    .H_DISPLAY (4), .H_FRONT (1), .H_SYNC (1), .H_BACK (1),
    .V_DISPLAY (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .TICK_DIV  (2)
  ) u_sm (
    .clk (clk),
    .rst (rst),
    .vga (bus_sm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected {frame_start, p_tick, video_on, vsync, hsync, y, x} after
  // n clk edges since reset release.
  function automatic logic [24:0] exp_vec(input int n, input int td,
      input int hd, input int hf, input int hs, input int ht,
      input int vd, input int vf, input int vs, input int vt);
    int p, x, y;
    logic e_hs, e_vs, e_vo, e_pt, e_fs;
    p    = n / td;
    x    = p % ht;
    y    = (p / ht) % vt;
    e_hs = !((x >= hd + hf) && (x < hd + hf + hs));
    e_vs = !((y >= vd + vf) && (y < vd + vf + vs));
    e_vo = (x < hd) && (y < vd);
    e_pt = ((n % td) == td - 1);
    e_fs = (n > 0) && ((n % (td * ht * vt)) == 0);
    return {e_fs, e_pt, e_vo, e_vs, e_hs, 10'(y), 10'(x)};
  endfunction

  function automatic logic [24:0] obs_def();
    return {bus_def.frame_start, bus_def.p_tick, bus_def.video_on,
            bus_def.vsync, bus_def.hsync, bus_def.pixel_y, bus_def.pixel_x};
  endfunction

  function automatic logic [24:0] obs_sm();
    return {bus_sm.frame_start, bus_sm.p_tick, bus_sm.video_on,
            bus_sm.vsync, bus_sm.hsync, bus_sm.pixel_y, bus_sm.pixel_x};
  endfunction

  localparam int NCYC = 6001;

  initial begin
    int n;
    int def_model_errs, def_bound_errs, sm_model_errs, sm_bound_errs;
    int sm_vs_errs, sm_fs_cnt, sm_fs_first, sm_fs_second;
    int sm_vis0, sm_vis1, sm_hs_falls;
    int def_hs_fall_x, def_hs_rise_x, def_vo_fall_x, def_wrap_n, def_wrap_y;
    int first_tick_n, vo_first;
    logic prev_hs_def, prev_vo_def, prev_hs_sm;

    checks = 0; failures = 0;
    def_model_errs = 0; def_bound_errs = 0; sm_model_errs = 0;
    sm_bound_errs = 0; sm_vs_errs = 0; sm_fs_cnt = 0;
    sm_fs_first = -1; sm_fs_second = -1; sm_vis0 = 0; sm_vis1 = 0;
    sm_hs_falls = 0; def_hs_fall_x = -1; def_hs_rise_x = -1;
    def_vo_fall_x = -1; def_wrap_n = -1; def_wrap_y = -1;
    first_tick_n = -1; vo_first = -1;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_hsync",    bus_def.hsync,       1);
    check_val("rst_vsync",    bus_def.vsync,       1);
    check_val("rst_video_on", bus_def.video_on,    0);
    check_val("rst_p_tick",   bus_def.p_tick,      0);
    check_val("rst_x",        bus_def.pixel_x,     0);
    check_val("rst_y",        bus_def.pixel_y,     0);
    check_val("rst_frame",    bus_def.frame_start, 0);
    check_val("rst_sm_hsync", bus_sm.hsync,        1);
    check_val("rst_sm_vo",    bus_sm.video_on,     0);
    prev_hs_def = bus_def.hsync;
    prev_vo_def = bus_def.video_on;
    prev_hs_sm  = bus_sm.hsync;
    rst = 1'b1;

    for (n = 1; n <= NCYC; n++) begin
      @(posedge clk);
      @(negedge clk);

      if (obs_def() !== exp_vec(n, 4, 640, 16, 96, 800, 480, 10, 2, 525))
        def_model_errs++;
      if (bus_def.pixel_x >= 10'd800 || bus_def.pixel_y >= 10'd525)
        def_bound_errs++;
      if (n == 1) vo_first = bus_def.video_on;
      if (first_tick_n < 0 && bus_def.p_tick) first_tick_n = n;
      if (def_hs_fall_x < 0 && prev_hs_def && !bus_def.hsync)
        def_hs_fall_x = bus_def.pixel_x;
      if (def_hs_rise_x < 0 && def_hs_fall_x >= 0 && !prev_hs_def && bus_def.hsync)
        def_hs_rise_x = bus_def.pixel_x;
      if (def_vo_fall_x < 0 && prev_vo_def && !bus_def.video_on)
        def_vo_fall_x = bus_def.pixel_x;
      if (def_wrap_n < 0 && bus_def.pixel_y != 10'd0) begin
        def_wrap_n = n;
        def_wrap_y = (bus_def.pixel_x == 10'd0) ? int'(bus_def.pixel_y) : -1;
      end
      prev_hs_def = bus_def.hsync;
      prev_vo_def = bus_def.video_on;

      if (obs_sm() !== exp_vec(n, 2, 4, 1, 1, 7, 3, 1, 1, 6))
        sm_model_errs++;
      if (bus_sm.pixel_x >= 10'd7 || bus_sm.pixel_y >= 10'd6)
        sm_bound_errs++;
      if ((bus_sm.vsync == 1'b0) != (bus_sm.pixel_y == 10'd4))
        sm_vs_errs++;
      if (n <= 168) begin
        if (bus_sm.frame_start) begin
          sm_fs_cnt++;
          if (sm_fs_first < 0) sm_fs_first = n;
          else if (sm_fs_second < 0) sm_fs_second = n;
        end
        if (bus_sm.video_on && bus_sm.p_tick) begin
          if (n <= 84) sm_vis0++;
          else sm_vis1++;
        end
        if (prev_hs_sm && !bus_sm.hsync) sm_hs_falls++;
      end
      prev_hs_sm = bus_sm.hsync;
    end

    check_val("video_on_first_edge", vo_first, 1);
    check_val("first_p_tick_edge",   first_tick_n, 3);
    check_val("hsync_fall_x",        def_hs_fall_x, 656);
    check_val("hsync_rise_x",        def_hs_rise_x, 752);
    check_val("video_on_fall_x",     def_vo_fall_x, 640);
    check_val("line_len_clk",        def_wrap_n, 3200);
    check_val("line_wrap_y",         def_wrap_y, 1);
    check_val("def_model_errs",      def_model_errs, 0);
    check_val("def_bound_errs",      def_bound_errs, 0);
    check_val("sm_model_errs",       sm_model_errs, 0);
    check_val("sm_bound_errs",       sm_bound_errs, 0);
    check_val("sm_vsync_errs",       sm_vs_errs, 0);
    check_val("sm_frame_cnt",        sm_fs_cnt, 2);
    check_val("sm_frame_first",      sm_fs_first, 84);
    check_val("sm_frame_period",     sm_fs_second - sm_fs_first, 84);
    check_val("sm_vis_frame0",       sm_vis0, 12);
    check_val("sm_vis_frame1",       sm_vis1, 12);
    check_val("sm_hsync_pulses",     sm_hs_falls, 12);

    // Mid-line reset while hsync is low, applied between clock edges.
    check_val("pre_rst_x",     bus_def.pixel_x, 700);
    check_val("pre_rst_hsync", bus_def.hsync,   0);
    #2 rst = 1'b0;
    #1;
    check_val("async_hsync",    bus_def.hsync,    1);
    check_val("async_x",        bus_def.pixel_x,  0);
    check_val("async_y",        bus_def.pixel_y,  0);
    check_val("async_p_tick",   bus_def.p_tick,   0);
    check_val("async_video_on", bus_def.video_on, 0);
    check_val("async_sm_x",     bus_sm.pixel_x,   0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_ctrl.md
Name: vga_sync_ctrl

Overview:
- VGA timing controller that sequences the character-rendering datapath.
- Divides the 100 MHz system clock into a pixel tick and runs horizontal/vertical counters.
- Drives hsync/vsync, video_on, pixel_x and pixel_y; these feed the text generator and the RGB output stage.
- Also emits a frame_start strobe so downstream blocks can latch per-frame configuration.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- TICK_DIV, 4, clk cycles per pixel; must be ≥2

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high while (pixel_x, pixel_y) is in the visible area
- p_tick  out  1  one-clk pulse marking each pixel boundary
- pixel_x  out  10  current column, 0 .. H_TOTAL-1
- pixel_y  out  10  current line, 0 .. V_TOTAL-1
- frame_start  out  1  one-clk pulse when counters return to (0,0)

Behaviour:
- Derived constants: H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525.
- Reset, asynchronous on rst low, all regs registered:
  - div=0, pixel_x=0, pixel_y=0
  - hsync=1, vsync=1
  - video_on=0, p_tick=0, frame_start=0
- Divider:
  - div counts 0..TICK_DIV-1 and wraps to 0.
  - p_tick is registered. It is high during exactly the one clk cycle in which div==TICK_DIV-1, giving period TICK_DIV clk and duty 1/TICK_DIV.
- Counter advance: occurs at the clk edge that ends a cycle with p_tick=1.
  - pixel_x increments; at H_TOTAL-1 it wraps to 0.
  - pixel_y increments only on a pixel_x wrap; at V_TOTAL-1 it wraps to 0.
  - Counters hold on all other edges.
  - Width: 10-bit; parameters must give H_TOTAL, V_TOTAL ≤ 1024 (not checked in RTL).
- Decoded outputs (hsync, vsync, video_on):
  - Registered, and computed from the next-state counter values. They therefore change on the same edge as the counters and are never offset by a cycle.
  - hsync = 0 iff H_DISPLAY+H_FRONT ≤ x < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - vsync = 0 iff V_DISPLAY+V_FRONT ≤ y < V_DISPLAY+V_FRONT+V_SYNC (490..491).
  - video_on = 1 iff x < H_DISPLAY and y < V_DISPLAY.
  - Consequence: the first clk edge after rst rises loads video_on=1 (counters at 0,0).
- frame_start: registered, high for one clk cycle immediately following the edge where (x,y) goes from (H_TOTAL-1, V_TOTAL-1) to (0,0). It is not asserted on reset release.
- Boundary cases:
  - Line wrap and frame wrap occur on the same edge: pixel_y goes to 0 and pixel_x goes to 0 together, with no intermediate (0, V_TOTAL) value.
  - Reset mid-line or mid-sync pulse: outputs return to their reset values immediately, without waiting for a clk edge.
  - After reset release, the first p_tick occurs in the TICK_DIV-th cycle after release.
- Frame length: H_TOTAL·V_TOTAL·TICK_DIV clk = 1 680 000 at defaults (16.8 ms, 59.5 Hz).
- No enable input: the block free-runs whenever rst is high.

Test Plan:
- Reset and tick:
  - Stimulus: hold rst=0 for 3 clk, then release, defaults.
  - Response: during reset, hsync=vsync=1, video_on=0, x=y=0. After release, video_on=1 from the 1st edge; p_tick high for 1 clk every 4 clk, first in cycle 4.
- Horizontal timing:
  - Stimulus: run one full line.
  - Response: hsync falls on the edge where x becomes 656 and rises where x becomes 752. video_on falls where x becomes 640. The line lasts exactly 3200 clk. y increments when x wraps 799→0.
- Vertical and frame timing:
  - Stimulus: small parameters (H 4/1/1/1, V 3/1/1/1, TICK_DIV 2).
  - Response: H_TOTAL=7 and V_TOTAL=6. vsync is low only while y==4. frame_start pulses once every 84 clk, in the cycle after (6,5)→(0,0). video_on is 1 exactly 12 pixels per frame.
- Async reset mid-operation:
  - Stimulus: assert rst=0 between clk edges while hsync=0 (x=700).
  - Response: hsync=1, x=0, y=0 and p_tick=0 within that same cycle, with no clk edge required.
- Frame wrap regression:
  - Stimulus: run 2 full frames at defaults.
  - Response: frame_start count = 2, one pulse per 1 680 000 clk. No sample has x ≥ 800 or y ≥ 525. hsync low-pulse count = 1050.
